// File: rtl/ov_cam_pkg.sv
// Shared definitions for the OmniVision camera bring-up blocks.
package ov_cam_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP_WAIT,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_ACCEPT,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [15:0] END_MARKER    = 16'hFFFF;
  localparam logic [7:0]  DELAY_TAG     = 8'hF0;
  localparam logic [7:0]  DEF_CHIP_ADDR = 8'h42;

  // Largest of three elaboration-time counts, used to size the shared countdown.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ov_init_rom.sv
// Registered init table for the sensor: {subaddr, data} per entry, 1-cycle latency.
// Swap this file to retarget the sequencer to another sensor.
module ov_init_rom
  import ov_cam_pkg::*;
#(
  parameter int ROM_AW = 8
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [15:0]       data
);

  function automatic logic [15:0] lookup(input logic [ROM_AW-1:0] a);
    case (int'(a))
      0:       return 16'h1280;   // COM7: soft reset
      1:       return 16'hF00A;   // settle 10 ms after reset
      2:       return 16'h1204;   // COM7: RGB output
      3:       return 16'h1101;   // CLKRC: prescale
      4:       return 16'h40D0;   // COM15: RGB565 full range
      5:       return 16'h8C00;   // RGB444 off
      default: return END_MARKER;
    endcase
  endfunction

  // Table read is registered so it maps onto block RAM / ROM primitives.
  always_ff @(posedge clk) begin
    data <= lookup(addr);
  end

endmodule

// File: rtl/ov_sccb_init_seq.sv
// Power-on register init sequencer: walks the table ROM and issues one SCCB
// write per entry through ov_sccb, with delay entries, end marker and timeout.
module ov_sccb_init_seq
  import ov_cam_pkg::*;
#(
  parameter logic [7:0]  CHIP_ADDR      = DEF_CHIP_ADDR,
  parameter int          ROM_AW         = 8,
  parameter int unsigned CYCLES_PER_MS  = 50000,
  parameter int unsigned PWRUP_MS       = 3,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        sccb_addr,
  output logic [7:0]        sccb_subaddr,
  output logic [7:0]        sccb_w_data,
  output logic              sccb_start,
  input  logic              sccb_busy,
  input  logic              sccb_done,
  output logic              pwdn,
  output logic              init_busy,
  output logic              init_done,
  output logic              init_err,
  output logic [ROM_AW-1:0] err_index
);

  localparam int unsigned PWRUP_CYC = PWRUP_MS * CYCLES_PER_MS;
  localparam int unsigned DLY_MAX   = 255 * CYCLES_PER_MS;
  localparam int unsigned CNT_MAX   = max3(DLY_MAX, PWRUP_CYC, GAP_CYCLES);
  localparam int          CNT_W     = $clog2(CNT_MAX + 1);
  localparam int          TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state, next_state;
  logic [ROM_AW-1:0] index;
  logic [CNT_W-1:0]  cnt;
  logic [TMO_W-1:0]  tmo;
  logic [15:0]       entry;

  logic cnt_clr, cnt_inc, cnt_dec, cnt_load;
  logic idx_clr, idx_inc, issue, tmo_run, entry_ld, err_ld;
  logic pwrup_exp, gap_exp, tmo_exp, last;

  // Counters count up from 0 for power-up and gap; delay loads and counts down.
  assign pwrup_exp = (32'(cnt) + 32'd1) >= PWRUP_CYC;
  assign gap_exp   = (32'(cnt) + 32'd1) >= GAP_CYCLES;
  assign tmo_exp   = (32'(tmo) + 32'd1) >= TIMEOUT_CYCLES;
  assign last      = &index;

  assign rom_addr  = index;
  assign sccb_addr = CHIP_ADDR;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_PWRUP_WAIT;
    else        state <= next_state;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    cnt_dec    = 1'b0;
    cnt_load   = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    issue      = 1'b0;
    tmo_run    = 1'b0;
    entry_ld   = 1'b0;
    err_ld     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (init_start) begin
          next_state = ST_PWRUP_WAIT;
          cnt_clr    = 1'b1;
          idx_clr    = 1'b1;
        end
      end
      ST_PWRUP_WAIT: begin
        if (pwrup_exp) begin
          next_state = ST_FETCH;
          cnt_clr    = 1'b1;
          idx_clr    = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_FETCH: next_state = ST_DECODE;
      ST_DECODE: begin
        entry_ld = 1'b1;
        if (rom_data == END_MARKER) begin
          next_state = ST_DONE;
        end else if (rom_data[15:8] == DELAY_TAG) begin
          next_state = ST_DELAY;
          cnt_load   = 1'b1;
        end else begin
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!sccb_busy) begin
          next_state = ST_WAIT_ACCEPT;
          issue      = 1'b1;
        end
      end
      ST_WAIT_ACCEPT: begin
        // Any done seen here belongs to the previous write; wait for busy first.
        tmo_run = 1'b1;
        if (sccb_busy) begin
          next_state = ST_WAIT_DONE;
        end else if (tmo_exp) begin
          next_state = ST_ERROR;
          err_ld     = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        tmo_run = 1'b1;
        if (sccb_done) begin
          next_state = ST_GAP;
          cnt_clr    = 1'b1;
        end else if (tmo_exp) begin
          next_state = ST_ERROR;
          err_ld     = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_exp) begin
          cnt_clr = 1'b1;
          if (last) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_FETCH;
            idx_inc    = 1'b1;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DELAY: begin
        if (cnt == '0) begin
          if (last) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_FETCH;
            idx_inc    = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Counters, latched entry, SCCB request and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index        <= '0;
      cnt          <= '0;
      tmo          <= '0;
      entry        <= '0;
      sccb_start   <= 1'b0;
      sccb_subaddr <= '0;
      sccb_w_data  <= '0;
      pwdn         <= 1'b1;
      init_busy    <= 1'b0;
      init_done    <= 1'b0;
      init_err     <= 1'b0;
      err_index    <= '0;
    end else begin
      if (idx_clr)      index <= '0;
      else if (idx_inc) index <= index + 1'b1;

      if (cnt_clr)       cnt <= '0;
      else if (cnt_load) cnt <= CNT_W'(32'(rom_data[7:0]) * CYCLES_PER_MS);
      else if (cnt_inc)  cnt <= cnt + 1'b1;
      else if (cnt_dec)  cnt <= cnt - 1'b1;

      if (issue)        tmo <= '0;
      else if (tmo_run) tmo <= tmo + 1'b1;

      if (entry_ld) entry <= rom_data;

      // Write fields hold from the start pulse until the next issue.
      sccb_start <= issue;
      if (issue) begin
        sccb_subaddr <= entry[15:8];
        sccb_w_data  <= entry[7:0];
      end

      if (err_ld) err_index <= index;
      if (state == ST_PWRUP_WAIT) pwdn <= 1'b0;

      init_busy <= !(next_state inside {ST_IDLE, ST_DONE, ST_ERROR});
      init_done <= (next_state == ST_DONE);
      init_err  <= (next_state == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_ov_sccb_init_seq.sv
// Scoreboard bench for ov_sccb_init_seq with a behavioural ROM and ov_sccb model.
module tb_ov_sccb_init_seq;

  localparam int unsigned CPM   = 10;
  localparam int unsigned GAP   = 16;
  localparam int unsigned TMO   = 200;
  localparam int          AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic [7:0]    sccb_addr, sccb_subaddr, sccb_w_data;
  logic          sccb_start, sccb_busy, sccb_done;
  logic          pwdn, init_busy, init_done, init_err;
  logic [AW-1:0] err_index;

  ov_sccb_init_seq #(
    .CHIP_ADDR(8'h42), .ROM_AW(AW), .CYCLES_PER_MS(CPM), .PWRUP_MS(3),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(rst_n), .init_start(init_start), .rom_addr(rom_addr),
    .rom_data(rom_data), .sccb_addr(sccb_addr), .sccb_subaddr(sccb_subaddr),
    .sccb_w_data(sccb_w_data), .sccb_start(sccb_start), .sccb_busy(sccb_busy),
    .sccb_done(sccb_done), .pwdn(pwdn), .init_busy(init_busy), .init_done(init_done),
    .init_err(init_err), .err_index(err_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered table ROM
  logic [15:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // ov_sccb model: busy for busy_len cycles, then done (pulse or held level)
  int busy_len = 40;
  int hang_n = 0;
  bit done_level = 1'b0;
  int bcnt, acc_n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sccb_busy <= 1'b0; sccb_done <= 1'b0; bcnt <= 0; acc_n <= 0;
    end else if (sccb_start && !sccb_busy) begin
      sccb_busy <= 1'b1; sccb_done <= 1'b0; bcnt <= 0; acc_n <= acc_n + 1;
    end else if (sccb_busy) begin
      if (acc_n != hang_n && bcnt == busy_len - 1) begin
        sccb_busy <= 1'b0; sccb_done <= 1'b1;
      end else begin
        bcnt <= bcnt + 1;
      end
    end else if (!done_level) begin
      sccb_done <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected {subaddr, data} per start pulse
  logic [15:0] exp_q[$];
  bit have_last = 1'b0;
  int last_cyc = 0;
  int mon_starts = 0;
  logic prev_start = 1'b0;
  logic [15:0] e;

  // Monitor: every start pulse is popped and compared against the queue
  always @(negedge clk) begin
    if (rst_n && sccb_start) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start got %h%h%h expected none", sccb_addr, sccb_subaddr, sccb_w_data);
      end else begin
        e = exp_q.pop_front();
        if ({sccb_addr, sccb_subaddr, sccb_w_data} !== {8'h42, e}) begin
          errors++;
          $display("FAIL write_fields got %h%h%h expected 42%h", sccb_addr, sccb_subaddr, sccb_w_data, e);
        end
      end
      checks++;
      if (prev_start) begin
        errors++;
        $display("FAIL start_width got 2+ cycles expected 1");
      end
      if (have_last) begin
        checks++;
        if (cyc - last_cyc < int'(GAP)) begin
          errors++;
          $display("FAIL start_spacing got %0d expected >= %0d", cyc - last_cyc, GAP);
        end
      end
      have_last = 1'b1;
      last_cyc = cyc;
      mon_starts++;
    end
    prev_start = sccb_start;
  end

  task automatic load_table(input logic [15:0] t [$]);
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    for (int i = 0; i < t.size(); i++) rom[i] = t[i];
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pwdn"}, 32'(pwdn), 1);
    chk({tag, "_busy"}, 32'(init_busy), 0);
    chk({tag, "_done"}, 32'(init_done), 0);
    chk({tag, "_err"}, 32'(init_err), 0);
    chk({tag, "_err_index"}, 32'(err_index), 0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_start"}, 32'(sccb_start), 0);
    chk({tag, "_addr"}, 32'(sccb_addr), 32'h42);
    chk({tag, "_subaddr"}, 32'(sccb_subaddr), 0);
    chk({tag, "_wdata"}, 32'(sccb_w_data), 0);
  endtask

  // Holds reset for a few cycles, then releases on a falling edge
  task automatic apply_reset(output int rel_cyc);
    rst_n = 1'b0;
    exp_q.delete();
    have_last = 1'b0;
    mon_starts = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic wait_end(input string name, input int budget);
    int n;
    n = 0;
    while (!(init_done || init_err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_finished"}, 32'(init_done || init_err), 1);
  endtask

  task automatic wait_starts(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (mon_starts < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_reached"}, 32'(mon_starts >= target), 1);
  endtask

  task automatic push_t1();
    exp_q.push_back(16'h00CA); exp_q.push_back(16'h0AFE);
    exp_q.push_back(16'h10D0); exp_q.push_back(16'h1ABA);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int rel, t_nodly, t_dly, err_cyc, s2_cyc;
  logic [15:0] tbl [$];

  initial begin
    // Reset state and test 1: four writes back to back
    tbl = '{16'h00CA, 16'h0AFE, 16'h10D0, 16'h1ABA, 16'hFFFF};
    load_table(tbl);
    @(negedge clk);
    check_reset_vals("rst0");
    apply_reset(rel);
    push_t1();
    repeat (3) @(negedge clk);
    chk("t1_pwdn_low", 32'(pwdn), 0);
    chk("t1_busy_high", 32'(init_busy), 1);
    wait_end("t1", 2000);
    chk("t1_done", 32'(init_done), 1);
    chk("t1_busy_low", 32'(init_busy), 0);
    chk("t1_err", 32'(init_err), 0);
    chk("t1_starts", 32'(mon_starts), 4);
    chk("t1_queue_empty", 32'(exp_q.size()), 0);

    // Test 2: 2 ms delay entry vs. a 0 ms delay entry
    tbl = '{16'hF000, 16'h1234, 16'hFFFF};
    load_table(tbl);
    apply_reset(rel);
    exp_q.push_back(16'h1234);
    wait_end("t2a", 1000);
    t_nodly = last_cyc - rel;
    chk("t2a_starts", 32'(mon_starts), 1);
    tbl = '{16'hF002, 16'h1234, 16'hFFFF};
    load_table(tbl);
    apply_reset(rel);
    exp_q.push_back(16'h1234);
    wait_end("t2b", 1000);
    t_dly = last_cyc - rel;
    chk("t2b_starts", 32'(mon_starts), 1);
    chk("t2_delay_cycles", 32'(t_dly - t_nodly), 32'(2 * CPM));

    // Test 3: second write never completes -> timeout error at entry 1
    tbl = '{16'h00CA, 16'h0AFE, 16'h10D0, 16'hFFFF};
    load_table(tbl);
    hang_n = 2;
    apply_reset(rel);
    exp_q.push_back(16'h00CA); exp_q.push_back(16'h0AFE);
    wait_starts("t3_second", 2, 1000);
    s2_cyc = last_cyc;
    wait_end("t3", 1000);
    err_cyc = cyc;
    chk("t3_err", 32'(init_err), 1);
    chk("t3_done", 32'(init_done), 0);
    chk("t3_err_index", 32'(err_index), 1);
    chk("t3_busy_low", 32'(init_busy), 0);
    chk("t3_timeout_window", 32'((err_cyc - s2_cyc) >= int'(TMO) - 1 && (err_cyc - s2_cyc) <= int'(TMO) + 1), 1);
    repeat (300) @(negedge clk);
    chk("t3_no_more_starts", 32'(mon_starts), 2);
    hang_n = 0;

    // Test 4: done held high from the previous write must not skip the next one
    tbl = '{16'h00CA, 16'h0AFE, 16'h10D0, 16'h1ABA, 16'hFFFF};
    load_table(tbl);
    done_level = 1'b1;
    apply_reset(rel);
    push_t1();
    wait_end("t4", 2000);
    chk("t4_done", 32'(init_done), 1);
    chk("t4_starts", 32'(mon_starts), 4);
    chk("t4_queue_empty", 32'(exp_q.size()), 0);
    done_level = 1'b0;

    // Test 5: reset during the third write, then a clean restart from entry 0
    apply_reset(rel);
    push_t1();
    wait_starts("t5_third", 3, 1000);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("t5_midreset");
    apply_reset(rel);
    push_t1();
    repeat (3) @(negedge clk);
    chk("t5_pwdn_low", 32'(pwdn), 0);
    wait_end("t5", 2000);
    chk("t5_done", 32'(init_done), 1);
    chk("t5_starts", 32'(mon_starts), 4);

    // Test 6: replay after DONE, with an ignored init_start mid-sequence
    mon_starts = 0;
    have_last = 1'b0;
    push_t1();
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    chk("t6_done_cleared", 32'(init_done), 0);
    chk("t6_busy_again", 32'(init_busy), 1);
    wait_starts("t6_second", 2, 1000);
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    wait_end("t6", 2000);
    chk("t6_done", 32'(init_done), 1);
    chk("t6_starts", 32'(mon_starts), 4);
    chk("t6_queue_empty", 32'(exp_q.size()), 0);

    // Test 7: no end marker; last entry is processed, then DONE without wrap
    for (int i = 0; i < 255; i++) rom[i] = 16'hF000;
    rom[255] = 16'h55AA;
    apply_reset(rel);
    exp_q.push_back(16'h55AA);
    wait_end("t7", 3000);
    chk("t7_done", 32'(init_done), 1);
    repeat (50) @(negedge clk);
    chk("t7_starts", 32'(mon_starts), 1);
    chk("t7_rom_addr_held", 32'(rom_addr), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
